// File: rtl/meas_set_arbiter.sv
// Arbitrates NSRC measurement sets onto a single valid/ready transmit port.
// Optional macro MEAS_ORDER_FIX_EN swaps any min/max field pair captured out of order.
module meas_set_arbiter #(
  parameter int NSRC        = 4,
  parameter int NCH         = 2,
  parameter int W           = 16,
  parameter int TIMEOUT     = 1000000,
  parameter int VPP_DEF_MAX = 10000,
  parameter int FRE_DEF_MAX = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [NSRC-1:0]            src_valid,
  input  logic [NSRC*NCH*4*W-1:0]    src_data,
  output logic [NSRC-1:0]            src_ready,
  output logic [NCH*4*W-1:0]         tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [$clog2(NSRC)-1:0]    tx_src,
  output logic                       stale
);

  localparam int SW   = $clog2(NSRC);
  localparam int SETW = NCH * 4 * W;
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [4*W-1:0]  DEF_CH  = {W'(VPP_DEF_MAX), {W{1'b0}}, W'(FRE_DEF_MAX), {W{1'b0}}};
  localparam logic [SETW-1:0] DEF_SET = {NCH{DEF_CH}};

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_OFFER} state_t;

  state_t            r_state;
  logic [NSRC-1:0]   r_src_ready;
  logic [SETW-1:0]   r_tx_data;
  logic              r_tx_valid;
  logic [SW-1:0]     r_tx_src;
  logic              r_stale;
  logic [SW-1:0]     r_grant;
  logic [SW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;

  logic [SW-1:0]     w_grant;
  logic              w_any;
  logic [SETW-1:0]   w_cap;

  // Fixed priority scans from 0; round-robin scans from the slot after the last grant.
  always_comb begin
    int unsigned idx;
    logic        found;
    w_any   = |src_valid;
    w_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      idx = mode ? (32'(r_ptr) + 1 + k) % NSRC : k;
      if (!found && src_valid[idx]) begin
        found   = 1'b1;
        w_grant = SW'(idx);
      end
    end
  end

  always_comb begin
    w_cap = src_data[r_grant*SETW +: SETW];
`ifdef MEAS_ORDER_FIX_EN
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (w_cap[ch*4*W + p*2*W +: W] > w_cap[ch*4*W + p*2*W + W +: W]) begin
          w_cap[ch*4*W + p*2*W +: W]     = src_data[r_grant*SETW + ch*4*W + p*2*W + W +: W];
          w_cap[ch*4*W + p*2*W + W +: W] = src_data[r_grant*SETW + ch*4*W + p*2*W +: W];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_src_ready <= '0;
      r_tx_data   <= DEF_SET;
      r_tx_valid  <= 1'b0;
      r_tx_src    <= '0;
      r_stale     <= 1'b0;
      r_grant     <= '0;
      r_ptr       <= SW'(NSRC - 1);
      r_cnt       <= '0;
    end else begin
      if (r_state != S_CAPTURE && r_cnt != CW'(TIMEOUT))
        r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant     <= w_grant;
            r_src_ready <= NSRC'(1) << w_grant;
            r_state     <= S_CAPTURE;
          end else if (TIMEOUT != 0 && r_cnt == CW'(TIMEOUT) && !r_stale) begin
            r_tx_data  <= DEF_SET;
            r_stale    <= 1'b1;
            r_tx_valid <= 1'b1;
            r_state    <= S_OFFER;
          end
        end
        S_CAPTURE: begin
          r_src_ready <= '0;
          r_tx_data   <= w_cap;
          r_tx_src    <= r_grant;
          r_stale     <= 1'b0;
          r_cnt       <= '0;
          r_ptr       <= r_grant;
          r_tx_valid  <= 1'b1;
          r_state     <= S_OFFER;
        end
        S_OFFER: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign src_ready = r_src_ready;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_src    = r_tx_src;
  assign stale     = r_stale;

endmodule

// File: tb/tb_meas_set_arbiter.sv
// Randomised and directed bench for meas_set_arbiter against a per-cycle behavioural model.
module tb_meas_set_arbiter;
  localparam int NSRC = 4, NCH = 2, W = 16, TO = 50, SETW = NCH*4*W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic [NSRC-1:0] src_valid = '0;
  logic [NSRC*SETW-1:0] src_data = '0;
  logic [NSRC-1:0] src_ready;
  logic [SETW-1:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [1:0] tx_src;
  logic stale;

  meas_set_arbiter #(.NSRC(NSRC), .NCH(NCH), .W(W), .TIMEOUT(TO),
                     .VPP_DEF_MAX(10000), .FRE_DEF_MAX(50000)) dut (
    .clk(clk), .rst(rst), .mode(mode), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_src(tx_src), .stale(stale));

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [SETW-1:0] act, logic [SETW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [SETW-1:0] mkdef();
    logic [SETW-1:0] d = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      d[ch*64+48 +: 16] = 16'd10000;
      d[ch*64+16 +: 16] = 16'd50000;
    end
    return d;
  endfunction

  function automatic logic [SETW-1:0] fixset(logic [SETW-1:0] s);
    logic [SETW-1:0] r = s;
`ifdef MEAS_ORDER_FIX_EN
    logic [15:0] vmax, vmin, fmax, fmin;
    for (int ch = 0; ch < NCH; ch++) begin
      vmax = s[ch*64+48 +: 16]; vmin = s[ch*64+32 +: 16];
      fmax = s[ch*64+16 +: 16]; fmin = s[ch*64 +: 16];
      if (vmin > vmax) begin r[ch*64+48 +: 16] = vmin; r[ch*64+32 +: 16] = vmax; end
      if (fmin > fmax) begin r[ch*64+16 +: 16] = fmin; r[ch*64 +: 16] = fmax; end
    end
`endif
    return r;
  endfunction

  // Winner = requester with the smallest priority distance.
  function automatic int pick(logic [NSRC-1:0] v, bit rr, int ptr);
    int best = 0, bd = NSRC, d;
    for (int i = 0; i < NSRC; i++)
      if (v[i]) begin
        d = rr ? (i - ptr - 1 + 2*NSRC) % NSRC : i;
        if (d < bd) begin bd = d; best = i; end
      end
    return best;
  endfunction

  // Reference model: phase 0 waiting, 1 acknowledging a source, 2 offering a set.
  int m_phase, m_cnt, m_ptr, m_grant, m_src;
  bit m_stale, m_tv;
  logic [NSRC-1:0] m_rdy;
  logic [SETW-1:0] m_data;
  always @(posedge clk or negedge rst) begin
    int ph, c0;
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_ptr = NSRC-1; m_grant = 0; m_src = 0;
      m_stale = 0; m_tv = 0; m_rdy = '0; m_data = mkdef();
    end else begin
      ph = m_phase; c0 = m_cnt;
      if (ph != 1 && m_cnt < TO) m_cnt++;
      if (ph == 0) begin
        if (src_valid != '0) begin
          m_grant = pick(src_valid, mode, m_ptr);
          m_rdy = '0; m_rdy[m_grant] = 1'b1; m_phase = 1;
        end else if (c0 == TO && !m_stale) begin
          m_data = mkdef(); m_stale = 1; m_tv = 1; m_phase = 2;
        end
      end else if (ph == 1) begin
        m_rdy = '0;
        m_data = fixset(src_data[m_grant*SETW +: SETW]);
        m_src = m_grant; m_stale = 0; m_cnt = 0; m_ptr = m_grant; m_tv = 1; m_phase = 2;
      end else if (tx_ready) begin
        m_tv = 0; m_phase = 0;
      end
    end
  end

  logic [NSRC-1:0] ack = '0;
  logic [NSRC-1:0] gq[$];
  int gcyc[$], ocyc[$];
  logic [1:0] tq[$];
  bit sq[$];
  bit pv = 0;
  always @(negedge clk) begin
    if (!rst) begin
      ack = '0; pv = 0;
    end else begin
      chk("tx_valid", SETW'(tx_valid), SETW'(m_tv));
      chk("src_ready", SETW'(src_ready), SETW'(m_rdy));
      chk("tx_data", tx_data, m_data);
      chk("tx_src", SETW'(tx_src), SETW'(m_src));
      chk("stale", SETW'(stale), SETW'(m_stale));
      ack = src_ready;
      if (src_ready != '0) begin gq.push_back(src_ready); gcyc.push_back(cyc); end
      if (tx_valid && !pv) begin tq.push_back(tx_src); sq.push_back(stale); ocyc.push_back(cyc); end
      pv = tx_valid;
    end
  end

  logic [NSRC-1:0] sv = '0;
  logic [NSRC*SETW-1:0] sd = '0;
  int policy = 0;
  bit quiet = 0;

  task automatic raise(int i);
    sv[i] = 1'b1;
    sd[i*SETW +: SETW] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drive();
    src_valid = sv; src_data = sd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < NSRC; i++) begin
      if (ack[i]) begin
        sv[i] = 1'b0;
        if (policy == 1 || (policy == 2 && !quiet && $urandom_range(0,3) == 0)) raise(i);
      end else if (policy == 2 && !quiet && !sv[i] && $urandom_range(0,9) == 0) raise(i);
    end
    if (policy == 2) begin
      tx_ready = ($urandom_range(0,3) != 0);
      if ($urandom_range(0,15) == 0) mode = ~mode;
    end
    drive();
  endtask

  task automatic clrq();
    gq.delete(); gcyc.delete(); tq.delete(); sq.delete(); ocyc.delete();
  endtask

  function automatic int nstale();
    int n = 0;
    foreach (sq[i]) if (sq[i]) n++;
    return n;
  endfunction

  initial begin
    logic [SETW-1:0] dsave;
    int c0, c2, k;
    #2 rst = 1'b0;
    #1;
    chk("rst_tx_data", tx_data, mkdef());
    chk("rst_tx_valid", SETW'(tx_valid), '0);
    chk("rst_src_ready", SETW'(src_ready), '0);
    chk("rst_stale", SETW'(stale), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_tx_data", tx_data, {16'd10000, 16'd0, 16'd50000, 16'd0, 16'd10000, 16'd0, 16'd50000, 16'd0});

    // Fixed priority with sources 1 and 3 pending
    clrq(); mode = 0; tx_ready = 1; raise(1); raise(3); drive();
    repeat (12) tick();
    chk("fp_grants", SETW'(gq.size()), SETW'(2));
    chk("fp_grant0", SETW'(gq[0]), SETW'(4'b0010));
    chk("fp_grant1", SETW'(gq[1]), SETW'(4'b1000));
    chk("fp_src0", SETW'(tq[0]), SETW'(1));
    chk("fp_src1", SETW'(tq[1]), SETW'(3));
    chk("fp_latency", SETW'(ocyc[0] - gcyc[0]), SETW'(1));
    chk("fp_spacing", SETW'(gcyc[1] - gcyc[0]), SETW'(3));

    // Round-robin with all sources continuously pending
    clrq(); mode = 1; policy = 1;
    for (int i = 0; i < NSRC; i++) raise(i);
    drive();
    for (k = 0; k < 40 && gq.size() < 5; k++) tick();
    policy = 0;
    for (k = 0; k < 40 && sv != '0; k++) tick();
    repeat (3) tick();
    chk("rr_g0", SETW'(gq[0]), SETW'(4'b0001));
    chk("rr_g1", SETW'(gq[1]), SETW'(4'b0010));
    chk("rr_g2", SETW'(gq[2]), SETW'(4'b0100));
    chk("rr_g3", SETW'(gq[3]), SETW'(4'b1000));
    chk("rr_g4", SETW'(gq[4]), SETW'(4'b0001));

    // Backpressure: src 2 waits while an offer is held
    clrq(); mode = 0; tx_ready = 0; raise(0); drive();
    for (k = 0; k < 10 && tq.size() < 1; k++) tick();
    raise(2); drive(); dsave = tx_data;
    repeat (20) tick();
    chk("bp_no_grant", SETW'(gq.size()), SETW'(1));
    chk("bp_valid_held", SETW'(tx_valid), SETW'(1));
    chk("bp_data_stable", tx_data, dsave);
    tx_ready = 1;
    for (k = 0; k < 10 && gq.size() < 2; k++) tick();
    chk("bp_grant2", SETW'(gq[1]), SETW'(4'b0100));
    repeat (4) tick();

    // Timeout: one stale offer, defaults, tx_src held
    clrq(); raise(0); drive();
    for (k = 0; k < 10 && gq.size() < 1; k++) tick();
    c0 = gcyc[0];
    while (cyc < c0 + 120) tick();
    chk("to_stale_count", SETW'(nstale()), SETW'(1));
    chk("to_stale_delay", SETW'(ocyc[1] - c0), SETW'(52));
    chk("to_src_held", SETW'(tq[1]), SETW'(0));
    chk("to_defaults", tx_data, mkdef());
    chk("to_stale_flag", SETW'(stale), SETW'(1));
    raise(1); drive();
    for (k = 0; k < 10 && tq.size() < 3; k++) tick();
    chk("to_cleared", SETW'(sq[2]), SETW'(0));
    c2 = gcyc[1];
    clrq();
    for (k = 0; k < 200 && cyc < c2 + 51; k++) tick();
    raise(2); drive();
    repeat (6) tick();
    chk("to_src_wins", SETW'(nstale()), SETW'(0));
    chk("to_win_grant", SETW'(gq[0]), SETW'(4'b0100));
    chk("to_win_cycle", SETW'(gcyc[0] - c2), SETW'(52));

    // Min/max ordering on capture, then reset during an offer
    clrq(); tx_ready = 0; raise(0);
    sd[48 +: 16] = 16'd100; sd[32 +: 16] = 16'd300; drive();
    for (k = 0; k < 10 && tq.size() < 1; k++) tick();
`ifdef MEAS_ORDER_FIX_EN
    chk("ord_vpp_max", SETW'(tx_data[48 +: 16]), SETW'(300));
    chk("ord_vpp_min", SETW'(tx_data[32 +: 16]), SETW'(100));
`else
    chk("ord_vpp_max", SETW'(tx_data[48 +: 16]), SETW'(100));
    chk("ord_vpp_min", SETW'(tx_data[32 +: 16]), SETW'(300));
`endif
    #2 rst = 1'b0; sv = '0; drive();
    #1;
    chk("mid_rst_valid", SETW'(tx_valid), '0);
    chk("mid_rst_data", tx_data, mkdef());
    chk("mid_rst_ready", SETW'(src_ready), '0);
    @(negedge clk) rst = 1'b1;
    clrq(); mode = 1; tx_ready = 1; raise(0); raise(3); drive();
    for (k = 0; k < 10 && gq.size() < 1; k++) tick();
    chk("rst_ptr_first", SETW'(gq[0]), SETW'(4'b0001));
    repeat (12) tick();

    // Randomised traffic with periodic silent gaps
    policy = 2;
    for (int n = 0; n < 3000; n++) begin
      quiet = (n % 400) >= 300;
      tick();
    end
    policy = 0; quiet = 1; tx_ready = 1;
    repeat (20) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
